// File: rtl/hazard_unit_pkg.sv
// Shared encodings for the hazard unit: operand-forwarding selects and memory-wait FSM states.
// The datapath operand muxes import the same forwarding constants.
package hazard_unit_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [1:0] ST_RUN  = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_ERR  = 2'b10;

  localparam int WAIT_CNT_W = 16;

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter: increments on inc_i and sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: stage bubble/flush controls, EX operand forwarding selects,
// data-memory wait FSM with sticky timeout, and saturating stall/redirect counters.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       reg1_src_ID,
  input  logic [4:0]       reg2_src_ID,
  input  logic [4:0]       reg1_src_EX,
  input  logic [4:0]       reg2_src_EX,
  input  logic [4:0]       reg_dest_EX,
  input  logic [4:0]       reg_dest_MEM,
  input  logic [4:0]       reg_dest_WB,
  input  logic             load_EX,
  input  logic             reg_write_MEM,
  input  logic             reg_write_WB,
  input  logic             br_taken_EX,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             bubbleF,
  output logic             bubbleD,
  output logic             bubbleE,
  output logic             bubbleM,
  output logic             bubbleW,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             flushW,
  output logic [1:0]       op1_sel,
  output logic [1:0]       op2_sel,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LIM = WAIT_CNT_W'(MEM_TIMEOUT);

  logic [1:0]            state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  timeout_q, timeout_d;
  logic                  load_use, mem_stall, redirect;

  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic wr_mem,
                                         input logic [4:0] dst_mem, input logic wr_wb,
                                         input logic [4:0] dst_wb);
    if (wr_mem && (dst_mem != 5'd0) && (dst_mem == src))   return FWD_MEM;
    else if (wr_wb && (dst_wb != 5'd0) && (dst_wb == src)) return FWD_WB;
    else                                                   return FWD_RF;
  endfunction

  assign load_use  = load_EX && (reg_dest_EX != 5'd0) &&
                     ((reg_dest_EX == reg1_src_ID) || (reg_dest_EX == reg2_src_ID));
  assign mem_stall = dmem_req && !dmem_ready;

  // Stage controls in strict priority; a memory stall freezes everything so redirects re-evaluate later.
  always_comb begin
    {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW} = 5'b0;
    {flushD, flushE, flushM, flushW}              = 4'b0;
    redirect                                      = 1'b0;
    op1_sel                                       = FWD_RF;
    op2_sel                                       = FWD_RF;
    if (rst) begin
      {flushD, flushE, flushM, flushW} = 4'b1111;
    end else begin
      op1_sel = fwd_sel(reg1_src_EX, reg_write_MEM, reg_dest_MEM, reg_write_WB, reg_dest_WB);
      op2_sel = fwd_sel(reg2_src_EX, reg_write_MEM, reg_dest_MEM, reg_write_WB, reg_dest_WB);
      if ((state_q == ST_ERR) || mem_stall) begin
        {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW} = 5'b11111;
      end else if (br_taken_EX) begin
        flushD   = 1'b1;
        flushE   = 1'b1;
        redirect = 1'b1;
      end else if (load_use) begin
        bubbleF = 1'b1;
        bubbleD = 1'b1;
        flushE  = 1'b1;
      end
    end
  end

  // Ready is checked before the limit, so a completion on the final allowed cycle is not a timeout.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WAIT_CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (dmem_ready || !dmem_req) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == TIMEOUT_LIM) begin
          state_d   = ST_ERR;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        end
      end
      ST_ERR:  state_d = ST_ERR;
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign mem_timeout = timeout_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (bubbleF),
    .cnt_o (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (redirect),
    .cnt_o (flush_events)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized traffic against a
// priority-table / run-length reference model evaluated every cycle.
module tb_hazard_unit;

  localparam int TO   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] reg1_src_ID, reg2_src_ID, reg1_src_EX, reg2_src_EX;
  logic [4:0] reg_dest_EX, reg_dest_MEM, reg_dest_WB;
  logic load_EX, reg_write_MEM, reg_write_WB, br_taken_EX, dmem_req, dmem_ready;
  logic bubbleF, bubbleD, bubbleE, bubbleM, bubbleW;
  logic flushD, flushE, flushM, flushW;
  logic [1:0] op1_sel, op2_sel;
  logic mem_timeout;
  logic [CW-1:0] stall_cycles, flush_events;

  int n_total = 0;
  int n_pass  = 0;

  // reference model state
  bit m_err   = 1'b0;
  int m_run   = 0;
  int m_stall = 0;
  int m_flush = 0;
  int prio;
  logic lu, ms;
  logic [8:0] exp_ctrl;

  always #5 clk = ~clk;

  hazard_unit #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .reg1_src_ID(reg1_src_ID), .reg2_src_ID(reg2_src_ID),
    .reg1_src_EX(reg1_src_EX), .reg2_src_EX(reg2_src_EX),
    .reg_dest_EX(reg_dest_EX), .reg_dest_MEM(reg_dest_MEM), .reg_dest_WB(reg_dest_WB),
    .load_EX(load_EX), .reg_write_MEM(reg_write_MEM), .reg_write_WB(reg_write_WB),
    .br_taken_EX(br_taken_EX), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .bubbleF(bubbleF), .bubbleD(bubbleD), .bubbleE(bubbleE), .bubbleM(bubbleM), .bubbleW(bubbleW),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .op1_sel(op1_sel), .op2_sel(op2_sel), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
  endtask

  function automatic int fwd_model(input logic [4:0] s);
    if (rst) return 0;
    if (reg_write_MEM && reg_dest_MEM != 0 && reg_dest_MEM == s) return 1;
    if (reg_write_WB && reg_dest_WB != 0 && reg_dest_WB == s) return 2;
    return 0;
  endfunction

  // Every cycle: expected controls from the priority table, counters from the model, then advance it.
  always @(negedge clk) begin
    if (rst) begin
      m_err = 0; m_run = 0; m_stall = 0; m_flush = 0;
    end
    lu = load_EX && reg_dest_EX != 0 && (reg_dest_EX == reg1_src_ID || reg_dest_EX == reg2_src_ID);
    ms = dmem_req && !dmem_ready;
    if (rst)              prio = 0;
    else if (m_err)       prio = 1;
    else if (ms)          prio = 2;
    else if (br_taken_EX) prio = 3;
    else if (lu)          prio = 4;
    else                  prio = 5;
    case (prio)
      0:       exp_ctrl = 9'b00000_1111;
      1, 2:    exp_ctrl = 9'b11111_0000;
      3:       exp_ctrl = 9'b00000_1100;
      4:       exp_ctrl = 9'b11000_0100;
      default: exp_ctrl = 9'b00000_0000;
    endcase
    chk("ctrl", int'({bubbleF, bubbleD, bubbleE, bubbleM, bubbleW, flushD, flushE, flushM, flushW}),
        int'(exp_ctrl));
    chk("op1_sel", int'(op1_sel), fwd_model(reg1_src_EX));
    chk("op2_sel", int'(op2_sel), fwd_model(reg2_src_EX));
    chk("mem_timeout", int'(mem_timeout), int'(m_err));
    chk("stall_cycles", int'(stall_cycles), m_stall);
    chk("flush_events", int'(flush_events), m_flush);
    if (!rst) begin
      if (prio == 1 || prio == 2 || prio == 4) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      if (prio == 3) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
      if (!m_err) begin
        m_run = ms ? m_run + 1 : 0;
        if (m_run == TO + 1) m_err = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    reg1_src_ID = 0; reg2_src_ID = 0; reg1_src_EX = 0; reg2_src_EX = 0;
    reg_dest_EX = 0; reg_dest_MEM = 0; reg_dest_WB = 0;
    load_EX = 0; reg_write_MEM = 0; reg_write_WB = 0; br_taken_EX = 0;
    dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    repeat (2) tick();
    chk("rst_flushD", int'(flushD), 1);
    chk("rst_bubbleF", int'(bubbleF), 0);
    chk("rst_stall", int'(stall_cycles), 0);
    rst = 1'b0;

    // forwarding priority and x0 exclusion
    reg_dest_MEM = 5; reg_write_MEM = 1; reg_dest_WB = 5; reg_write_WB = 1; reg1_src_EX = 5;
    #1 chk("fwd_mem", int'(op1_sel), 1);
    reg_write_MEM = 0;
    #1 chk("fwd_wb", int'(op1_sel), 2);
    reg_write_MEM = 1; reg_dest_MEM = 0; reg_dest_WB = 0; reg1_src_EX = 0;
    #1 chk("fwd_x0", int'(op1_sel), 0);
    tick();

    // load-use: one stall cycle, then none with rd=x0
    clear_inputs();
    load_EX = 1; reg_dest_EX = 7; reg2_src_ID = 7;
    #1 chk("lu_bubbleD", int'(bubbleD), 1);
    chk("lu_flushE", int'(flushE), 1);
    tick();
    load_EX = 0;
    #1 chk("lu_stall_cnt", int'(stall_cycles), 1);
    load_EX = 1; reg_dest_EX = 0; reg2_src_ID = 0;
    #1 chk("lu_x0_bubbleF", int'(bubbleF), 0);
    tick();

    // redirect discards simultaneous load-use
    clear_inputs();
    br_taken_EX = 1; load_EX = 1; reg_dest_EX = 7; reg2_src_ID = 7;
    #1 chk("redir_flushD", int'(flushD), 1);
    chk("redir_bubbleF", int'(bubbleF), 0);
    tick();
    clear_inputs();
    #1 chk("redir_cnt", int'(flush_events), 1);

    // memory wait with redirect pending
    do_reset();
    br_taken_EX = 1; dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("mw_bubbleW", int'(bubbleW), 1);
      chk("mw_flushD", int'(flushD), 0);
      tick();
    end
    dmem_ready = 1;
    #1 chk("mw_ready_flushD", int'(flushD), 1);
    chk("mw_stall_cnt", int'(stall_cycles), 3);
    tick();
    clear_inputs();
    #1 chk("mw_flush_cnt", int'(flush_events), 1);
    tick();

    // timeout after TO+1 stalled cycles, sticky, then async reset mid-cycle
    do_reset();
    dmem_req = 1; dmem_ready = 0;
    repeat (TO) tick();
    #1 chk("to_not_yet", int'(mem_timeout), 0);
    tick();
    #1 chk("to_fired", int'(mem_timeout), 1);
    dmem_ready = 1;
    #1 chk("to_err_bubbleM", int'(bubbleM), 1);
    repeat (2) tick();
    #1 rst = 1'b1;
    #1 chk("arst_timeout", int'(mem_timeout), 0);
    chk("arst_stall", int'(stall_cycles), 0);
    chk("arst_flushE", int'(flushE), 1);
    tick();
    rst = 1'b0;
    clear_inputs();
    tick();

    // saturation
    load_EX = 1; reg_dest_EX = 3; reg1_src_ID = 3;
    repeat (20) tick();
    chk("sat_stall", int'(stall_cycles), CMAX);
    clear_inputs();
    do_reset();

    // randomized traffic in segments with varying memory readiness
    for (int seg = 0; seg < 30; seg++) begin
      int rdy_pct;
      rdy_pct = int'($urandom_range(10, 90));
      for (int c = 0; c < 60; c++) begin
        rst           = ($urandom_range(0, 80) == 0);
        reg1_src_ID   = 5'($urandom_range(0, 3));
        reg2_src_ID   = 5'($urandom_range(0, 3));
        reg1_src_EX   = 5'($urandom_range(0, 3));
        reg2_src_EX   = 5'($urandom_range(0, 3));
        reg_dest_EX   = 5'($urandom_range(0, 3));
        reg_dest_MEM  = 5'($urandom_range(0, 3));
        reg_dest_WB   = 5'($urandom_range(0, 3));
        load_EX       = 1'($urandom_range(0, 1));
        reg_write_MEM = 1'($urandom_range(0, 1));
        reg_write_WB  = 1'($urandom_range(0, 1));
        br_taken_EX   = ($urandom_range(0, 3) == 0);
        dmem_req      = 1'($urandom_range(0, 1));
        dmem_ready    = (int'($urandom_range(0, 99)) < rdy_pct);
        tick();
      end
      if (seg % 3 == 2) do_reset();
    end

    clear_inputs();
    rst = 1'b0;
    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
